sound_request_sequencer: RTL and testbench

Upstream driver for the tone-generation block (consumes `sound_code[2:0]` and level `play_sound`). It collects one-cycle game-event pulses and queues them. It presents each event as a stable code with `play_sound` held high for a fixed play window, followed by a forced silent gap so the tone generator sees distinct requests. Game-over preempts everything.

---
 rtl/sound_request_sequencer_if.sv | 25 ++
 rtl/sound_request_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_sound_request_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_request_sequencer_if.sv
// Request/response bundle between the game-event source and the sound
// request sequencer: event pulses in, tone-generator request level out.
interface sound_request_sequencer_if;
  logic [6:0] ev;
  logic [2:0] sound_code;
  logic       play_sound;
  logic       busy;
  logic       drop;

  modport master (
    output ev,
    input  sound_code,
    input  play_sound,
    input  busy,
    input  drop
  );

  modport slave (
    input  ev,
    output sound_code,
    output play_sound,
    output busy,
    output drop
  );
endinterface

// File: rtl/sound_request_sequencer.sv
// Sound request sequencer: encodes one-cycle game-event pulses, queues them,
// and presents each as a stable code with play_sound held for a fixed play
// window followed by a forced silent gap. Game over (code 7) preempts.
module sound_request_sequencer #(
  parameter int PLAY_CYCLES = 300_000_000,
  parameter int GAP_CYCLES  = 10_000_000,
  parameter int DEPTH       = 4
) (
  input logic                      clk,
  input logic                      rstn,
  sound_request_sequencer_if.slave bus
);

  localparam int MAX_CYCLES = (PLAY_CYCLES > GAP_CYCLES) ? PLAY_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int FCNT_W     = PTR_W + 1;

  localparam logic [CNT_W-1:0]  PLAY_LOAD    = CNT_W'(PLAY_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [FCNT_W-1:0] FCNT_ZERO    = {FCNT_W{1'b0}};
  localparam logic [FCNT_W-1:0] FCNT_ONE     = FCNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_FULL    = FCNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ZERO     = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE      = PTR_W'(1);
  localparam logic [2:0]        CODE_NONE    = 3'd0;
  localparam logic [2:0]        CODE_PREEMPT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Highest set event bit wins; simultaneous lower events are discarded.
  function automatic logic [2:0] encode_event(input logic [6:0] ev_bits);
    logic [2:0] code;
    casez (ev_bits)
      7'b1??????: code = 3'd7;
      7'b01?????: code = 3'd6;
      7'b001????: code = 3'd5;
      7'b0001???: code = 3'd4;
      7'b00001??: code = 3'd3;
      7'b000001?: code = 3'd2;
      7'b0000001: code = 3'd1;
      default:    code = 3'd0;
    endcase
    return code;
  endfunction

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic [2:0]        code_r;
  logic [2:0]        code_s;
  logic              play_r;
  logic              play_s;
  logic              busy_r;
  logic              busy_s;
  logic              drop_r;
  logic              drop_s;

  logic [2:0]        fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [FCNT_W-1:0] fcnt_r;
  logic [FCNT_W-1:0] fcnt_next_s;

  logic [2:0]        ev_code_s;
  logic [2:0]        head_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              queued_code_s;
  logic              preempt_s;
  logic              pop_s;
  logic              push_s;

  assign ev_code_s     = encode_event(bus.ev);
  assign head_s        = fifo_mem_r[rd_ptr_r];
  assign fifo_empty_s  = (fcnt_r == FCNT_ZERO);
  assign fifo_full_s   = (fcnt_r == FCNT_FULL);
  assign queued_code_s = (ev_code_s != CODE_NONE) && (ev_code_s != CODE_PREEMPT);

  // A game-over request is redundant if game over is already sounding or next in line.
  assign preempt_s = (ev_code_s == CODE_PREEMPT)
                   && !((state_r == PLAY) && (code_r == CODE_PREEMPT))
                   && !(!fifo_empty_s && (head_s == CODE_PREEMPT));

  // Sequencer next state: preempt forces a fresh gap, otherwise play/gap timing.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    code_s  = code_r;
    play_s  = play_r;
    pop_s   = 1'b0;
    if (preempt_s) begin
      code_s = CODE_NONE;
      play_s = 1'b0;
      if (state_r == IDLE) begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end else begin
        state_s = GAP;
        cnt_s   = GAP_LOAD;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            state_s = PLAY;
            cnt_s   = PLAY_LOAD;
            code_s  = head_s;
            play_s  = 1'b1;
            pop_s   = 1'b1;
          end else begin
            cnt_s = CNT_ZERO;
          end
        end
        PLAY: begin
          if (cnt_r == CNT_ZERO) begin
            state_s = GAP;
            cnt_s   = GAP_LOAD;
            code_s  = CODE_NONE;
            play_s  = 1'b0;
          end else begin
            cnt_s = cnt_r - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_r == CNT_ZERO) begin
            if (!fifo_empty_s) begin
              state_s = PLAY;
              cnt_s   = PLAY_LOAD;
              code_s  = head_s;
              play_s  = 1'b1;
              pop_s   = 1'b1;
            end else begin
              state_s = IDLE;
              cnt_s   = CNT_ZERO;
            end
          end else begin
            cnt_s = cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          code_s  = CODE_NONE;
          play_s  = 1'b0;
        end
      endcase
    end
  end

  // Queue write/discard decision and resulting occupancy; a pop frees a slot the same edge.
  always_comb begin
    push_s = queued_code_s && (!fifo_full_s || pop_s);
    drop_s = queued_code_s && fifo_full_s && !pop_s;
    if (preempt_s) begin
      fcnt_next_s = FCNT_ONE;
    end else begin
      case ({push_s, pop_s})
        2'b10:   fcnt_next_s = fcnt_r + FCNT_ONE;
        2'b01:   fcnt_next_s = fcnt_r - FCNT_ONE;
        default: fcnt_next_s = fcnt_r;
      endcase
    end
    busy_s = (state_s != IDLE) || (fcnt_next_s != FCNT_ZERO);
  end

  // Sequencer state, window counter and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      code_r  <= CODE_NONE;
      play_r  <= 1'b0;
      busy_r  <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      code_r  <= code_s;
      play_r  <= play_s;
      busy_r  <= busy_s;
      drop_r  <= drop_s;
    end
  end

  // Request FIFO: preempt flushes and leaves game over as the only entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= CODE_NONE;
      end
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      fcnt_r   <= FCNT_ZERO;
    end else if (preempt_s) begin
      fifo_mem_r[0] <= CODE_PREEMPT;
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ONE;
      fcnt_r        <= FCNT_ONE;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= ev_code_s;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      fcnt_r <= fcnt_next_s;
    end
  end

  assign bus.sound_code = code_r;
  assign bus.play_sound = play_r;
  assign bus.busy       = busy_r;
  assign bus.drop       = drop_r;

endmodule

// File: tb/tb_sound_request_sequencer.sv
// Bench for sound_request_sequencer: directed scenarios plus random event
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_sound_request_sequencer;

  localparam int PLAY  = 8;
  localparam int GAP   = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn;

  sound_request_sequencer_if bus ();

  sound_request_sequencer #(
    .PLAY_CYCLES(PLAY),
    .GAP_CYCLES (GAP),
    .DEPTH      (DEPTH)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending requests, cycles left in the current window.
  int q[$];
  int play_left;
  int gap_left;
  int cur_code;
  bit m_drop;

  logic [6:0] stim [64];
  int   code_cycles [8];
  int   drop_count;
  int   drop_at;
  logic busy_seen [64];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int top_code(input logic [6:0] e);
    for (int i = 6; i >= 0; i--) begin
      if (e[i]) return i + 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    q.delete();
    play_left = 0;
    gap_left  = 0;
    cur_code  = 0;
    m_drop    = 0;
  endtask

  // Advance the model by one clock edge given the events seen this cycle.
  task automatic model_step(input logic [6:0] e);
    int c;
    bit playing;
    bit gapping;
    bit start;
    c       = top_code(e);
    playing = (play_left > 0);
    gapping = (gap_left > 0);
    m_drop  = 0;
    if (c == 7 && !(playing && cur_code == 7) && !(q.size() > 0 && q[0] == 7)) begin
      q.delete();
      q.push_back(7);
      if (playing || gapping) begin
        play_left = 0;
        gap_left  = GAP;
      end
    end else begin
      start = (q.size() > 0) && ((!playing && !gapping) || gap_left == 1);
      if (c >= 1 && c <= 6) begin
        if (q.size() < DEPTH || start) q.push_back(c);
        else m_drop = 1;
      end
      if (playing) begin
        play_left--;
        if (play_left == 0) gap_left = GAP;
      end else if (start) begin
        cur_code  = q.pop_front();
        play_left = PLAY;
        gap_left  = 0;
      end else if (gapping) begin
        gap_left--;
      end
    end
  endtask

  // Check this cycle's outputs, then present this cycle's events.
  task automatic run_cycle(input logic [6:0] e);
    @(negedge clk);
    check_eq("play_sound", int'(bus.play_sound), (play_left > 0) ? 1 : 0);
    check_eq("sound_code", int'(bus.sound_code), (play_left > 0) ? cur_code : 0);
    check_eq("busy", int'(bus.busy),
             (play_left > 0 || gap_left > 0 || q.size() > 0) ? 1 : 0);
    check_eq("drop", int'(bus.drop), int'(m_drop));
    bus.ev = e;
    model_step(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.ev = 7'd0;
    rstn   = 1'b0;
    #1;
    check_eq("rst_play_sound", int'(bus.play_sound), 0);
    check_eq("rst_sound_code", int'(bus.sound_code), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_drop", int'(bus.drop), 0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) stim[i] = 7'd0;
  endtask

  task automatic run_scenario(input int n);
    for (int c = 0; c < 8; c++) code_cycles[c] = 0;
    drop_count = 0;
    drop_at    = -1;
    for (int i = 0; i < n; i++) begin
      run_cycle(stim[i]);
      busy_seen[i] = bus.busy;
      if (bus.play_sound) code_cycles[bus.sound_code]++;
      if (bus.drop) begin
        drop_count++;
        drop_at = i;
      end
    end
  endtask

  initial begin
    logic [6:0] e;
    int r;
    int density;
    rstn   = 1'b0;
    bus.ev = 7'd0;
    model_reset();

    // Single code-3 request: play 2..9, gap 10..12, idle at 13.
    do_reset();
    clear_stim();
    stim[0] = 7'b0000100;
    run_scenario(16);
    check_eq("s1_code3_cycles", code_cycles[3], PLAY);
    check_eq("s1_busy_c12", int'(busy_seen[12]), 1);
    check_eq("s1_busy_c13", int'(busy_seen[13]), 0);

    // Codes 2, 3, 5 together: only code 5 plays, nothing dropped.
    do_reset();
    clear_stim();
    stim[0] = 7'b0010110;
    run_scenario(16);
    check_eq("s2_code5_cycles", code_cycles[5], PLAY);
    check_eq("s2_code2_cycles", code_cycles[2] + code_cycles[3], 0);
    check_eq("s2_drops", drop_count, 0);

    // Overflow: code 4 then five code-1 pulses; fifth one is dropped.
    do_reset();
    clear_stim();
    stim[0] = 7'b0001000;
    for (int i = 3; i <= 7; i++) stim[i] = 7'b0000001;
    run_scenario(60);
    check_eq("s3_drop_count", drop_count, 1);
    check_eq("s3_drop_cycle", drop_at, 8);
    check_eq("s3_code1_cycles", code_cycles[1], 4 * PLAY);
    check_eq("s3_code4_cycles", code_cycles[4], PLAY);

    // Game over preempts code 2 and flushes the queued code-1s.
    do_reset();
    clear_stim();
    stim[0] = 7'b0000010;
    stim[1] = 7'b0000001;
    stim[2] = 7'b0000001;
    stim[5] = 7'b1000000;
    run_scenario(24);
    check_eq("s4_code1_cycles", code_cycles[1], 0);
    check_eq("s4_code7_cycles", code_cycles[7], PLAY);
    check_eq("s4_code2_cycles", code_cycles[2], 4);
    check_eq("s4_busy_c20", int'(busy_seen[20]), 0);

    // Async reset mid-play of code 6 with two requests queued.
    do_reset();
    clear_stim();
    stim[0] = 7'b0100000;
    stim[1] = 7'b0000001;
    stim[2] = 7'b0000001;
    run_scenario(5);
    @(posedge clk);
    #2;
    check_eq("s5_playing_before_rst", int'(bus.play_sound), 1);
    rstn = 1'b0;
    #1;
    check_eq("s5_async_play_sound", int'(bus.play_sound), 0);
    check_eq("s5_async_sound_code", int'(bus.sound_code), 0);
    check_eq("s5_async_busy", int'(bus.busy), 0);
    check_eq("s5_async_drop", int'(bus.drop), 0);
    bus.ev = 7'd0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    clear_stim();
    run_scenario(50);
    check_eq("s5_post_rst_plays", code_cycles[1] + code_cycles[6], 0);

    // Repeated game over while it plays is ignored: one 8-cycle play.
    do_reset();
    clear_stim();
    stim[0] = 7'b1000000;
    stim[4] = 7'b1000000;
    run_scenario(16);
    check_eq("s6_code7_cycles", code_cycles[7], PLAY);

    // Random traffic in blocks of varying density.
    do_reset();
    for (int blk = 0; blk < 20; blk++) begin
      density = $urandom_range(5, 60);
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 99);
        if (r >= density)       e = 7'd0;
        else if (r * 10 < density * 8) e = 7'(1 << $urandom_range(0, 5));
        else if (r * 10 < density * 9) e = 7'($urandom);
        else                    e = 7'b1000000;
        run_cycle(e);
      end
    end
    for (int i = 0; i < 80; i++) run_cycle(7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
